// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: owns the PC, issues instruction fetches and
// sequences redirects, flushes and misaligned-target traps. Optional stats: PC_SEQ_STATS_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [1:0]  flag_branch,
  input  logic        branch_taken,
  input  logic [31:0] address_target,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        flush,
  output logic        misalign_trap,
  output logic [31:0] mtval
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [15:0] trap_count
`endif
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_JAL  = 2'b01,
    BR_JALR = 2'b10,
    BR_COND = 2'b11
  } branch_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        trap_q, trap_d;
  logic [31:0] mtval_q, mtval_d;

  logic    is_xfer;
  logic    redirect;
  logic    misaligned;
  logic    fetch_fire;
  branch_e br_kind;

  // Control-transfer decode; only acted on while fetching, so killed EX slots are ignored.
  always_comb begin
    br_kind    = branch_e'(flag_branch);
    is_xfer    = 1'b0;
    unique case (br_kind)
      BR_JAL, BR_JALR: is_xfer = 1'b1;
      BR_COND:         is_xfer = branch_taken;
      default:         is_xfer = 1'b0;
    endcase
    redirect   = (state_q == S_FETCH) & ex_valid & is_xfer;
    misaligned = (address_target[1:0] != 2'b00);
    imem_req   = rst_n & (state_q == S_FETCH) & ~stall & ~redirect;
    fetch_fire = imem_req & imem_ready;
  end

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    trap_d  = 1'b0;
    mtval_d = mtval_q;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        if (redirect) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_INIT;
          flush_d = 1'b1;
          if (misaligned) begin
            pc_d    = TRAP_VECTOR;
            mtval_d = address_target;
            trap_d  = 1'b1;
          end else begin
            pc_d = address_target;
          end
        end else if (fetch_fire) begin
          pc_d = pc_q + 32'd4;
        end
      end

      S_FLUSH: begin
        // flush_q is already high for this cycle; keep it only while more cycles remain.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_FETCH;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

`ifdef PC_SEQ_STATS_EN
  logic [31:0] redirect_count_q, redirect_count_d;
  logic [15:0] trap_count_q, trap_count_d;

  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_comb begin
    redirect_count_d = redirect_count_q;
    trap_count_d     = trap_count_q;
    if (redirect && (redirect_count_q != '1)) redirect_count_d = redirect_count_q + 32'd1;
    if (redirect && misaligned && (trap_count_q != '1)) trap_count_d = trap_count_q + 16'd1;
  end

  assign redirect_count = redirect_count_q;
  assign trap_count     = trap_count_q;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_RESET;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= 4'd0;
      flush_q <= 1'b0;
      trap_q  <= 1'b0;
      mtval_q <= 32'd0;
`ifdef PC_SEQ_STATS_EN
      redirect_count_q <= 32'd0;
      trap_count_q     <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      trap_q  <= trap_d;
      mtval_q <= mtval_d;
`ifdef PC_SEQ_STATS_EN
      redirect_count_q <= redirect_count_d;
      trap_count_q     <= trap_count_d;
`endif
    end
  end

  assign imem_addr     = pc_q;
  assign flush         = flush_q;
  assign misalign_trap = trap_q;
  assign mtval         = mtval_q;

endmodule
